// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and defaults for the alarm clock sequencer.
// Mode encoding, counter widths and default wrap limits.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    TSET = 2'b01,
    ASET = 2'b10
  } mode_t;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HRS_W = 5;
  localparam int DAY_W = 3;

  localparam int SEC_MAX_D = 59;
  localparam int MIN_MAX_D = 59;
  localparam int HRS_MAX_D = 23;
  localparam int DAY_MAX_D = 6;

  localparam logic [6:0] WEEKEND_D = 7'b1000001;
  localparam int BUZZ_SECS_D = 60;

endpackage

// File: rtl/clock_mode_ctrl_buzz.sv
// Alarm sounder: holds Buzz high for BUZZ_SECS ticks after a match.
// Disarm and reset both win over a new match.
module alarm_buzz_timer #(
  parameter int BUZZ_SECS = 60
) (
  input  logic Pulse,
  input  logic Reset,
  input  logic Alarmon,
  input  logic match,
  output logic Buzz
);

  localparam int CW = $clog2(BUZZ_SECS + 1);
  localparam logic [CW-1:0] LOAD = CW'(BUZZ_SECS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Pulse) begin
    if (!Reset || !Alarmon) begin
      Buzz <= 1'b0;
      cnt  <= '0;
    end else if (match) begin
      Buzz <= 1'b1;
      cnt  <= LOAD;
    end else if (Buzz) begin
      if (cnt == '0) Buzz <= 1'b0;
      else cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode FSM and counter-advance decode for the alarm clock datapath.
// Counters wrap themselves; this block only says when each advances.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int         SEC_MAX      = SEC_MAX_D,
  parameter int         MIN_MAX      = MIN_MAX_D,
  parameter int         HRS_MAX      = HRS_MAX_D,
  parameter int         DAY_MAX      = DAY_MAX_D,
  parameter logic [6:0] WEEKEND_MASK = WEEKEND_D,
  parameter int         BUZZ_SECS    = BUZZ_SECS_D
) (
  input  logic             Pulse,
  input  logic             Reset,
  input  logic             Timeset,
  input  logic             Alarmset,
  input  logic             Minadv,
  input  logic             Hrsadv,
  input  logic             Dayadv,
  input  logic             Alarmon,
  input  logic [SEC_W-1:0] TSec,
  input  logic [MIN_W-1:0] TMin,
  input  logic [HRS_W-1:0] THrs,
  input  logic [DAY_W-1:0] TDay,
  input  logic [MIN_W-1:0] AMin,
  input  logic [HRS_W-1:0] AHrs,
  output logic             SecEn,
  output logic             MinEn,
  output logic             HrsEn,
  output logic             DayEn,
  output logic             AMinEn,
  output logic             AHrsEn,
  output logic             DispAlarm,
  output logic [1:0]       Mode,
  output logic             Buzz
);

  localparam logic [SEC_W-1:0] SMAX = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] MMAX = MIN_W'(MIN_MAX);
  localparam logic [HRS_W-1:0] HMAX = HRS_W'(HRS_MAX);
  localparam logic [DAY_W-1:0] DMAX = DAY_W'(DAY_MAX);
  // Day codes past DAY_MAX are not real days, so never ring on them.
  localparam logic [7:0] WK = {1'b1, WEEKEND_MASK};

  mode_t state, nxt;
  logic  c_min, c_hrs, c_day;
  logic  quiet_day, match;

  always_ff @(posedge Pulse) begin
    if (!Reset) state <= RUN;
    else state <= nxt;
  end

  always_comb begin
    nxt = RUN;
    priority case (1'b1)
      Timeset:  nxt = TSET;
      Alarmset: nxt = ASET;
      default:  nxt = RUN;
    endcase
  end

  assign c_min = (TSec == SMAX);
  assign c_hrs = c_min & (TMin == MMAX);
  assign c_day = c_hrs & (THrs == HMAX);

  always_comb begin
    SecEn     = 1'b0;
    MinEn     = 1'b0;
    HrsEn     = 1'b0;
    DayEn     = 1'b0;
    AMinEn    = 1'b0;
    AHrsEn    = 1'b0;
    DispAlarm = 1'b0;
    if (Reset) begin
      unique case (state)
        RUN: begin
          SecEn = 1'b1;
          MinEn = c_min;
          HrsEn = c_hrs;
          DayEn = c_day;
        end
        TSET: begin
          MinEn = Minadv;
          HrsEn = Hrsadv;
          DayEn = Dayadv;
        end
        ASET: begin
          SecEn     = 1'b1;
          MinEn     = c_min;
          HrsEn     = c_hrs;
          DayEn     = c_day;
          AMinEn    = Minadv;
          AHrsEn    = Hrsadv;
          DispAlarm = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Mode = state;

  assign quiet_day = WK[TDay] | (TDay > DMAX);
  assign match = Alarmon & (state != TSET) & (TSec == '0)
               & (TMin == AMin) & (THrs == AHrs) & ~quiet_day;

  alarm_buzz_timer #(
    .BUZZ_SECS(BUZZ_SECS)
  ) u_buzz (
    .Pulse  (Pulse),
    .Reset  (Reset),
    .Alarmon(Alarmon),
    .match  (match),
    .Buzz   (Buzz)
  );

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Central sequencer for the lab 2 part 2 alarm clock datapath.
- Owns the RUN / time-set / alarm-set mode FSM and drives the per-counter advance enables for the time counters (sec/min/hrs/day) and alarm counters (min/hrs).
- Generates the gated, time-limited Buzz output.
- Sits between the manual buttons and the counter/display datapath inside the top level. Counters do their own modulo wrap; this block only decides when each one advances.

Parameters:
- SEC_MAX, 59, last seconds value before wrap
- MIN_MAX, 59, last minutes value before wrap
- HRS_MAX, 23, last hours value before wrap (24 h internal)
- DAY_MAX, 6, last day value before wrap (0=Sun..6=Sat)
- WEEKEND_MASK, 7'b1000001, bit d set = alarm suppressed on day d
- BUZZ_SECS, 60, number of Pulse cycles Buzz stays high once triggered

Ports:
- Pulse  in  1  clock, 1 Hz tick; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- Timeset  in  1  level: hold time-set mode
- Alarmset  in  1  level: hold alarm-set mode
- Minadv  in  1  manual minute advance
- Hrsadv  in  1  manual hour advance
- Dayadv  in  1  manual day advance
- Alarmon  in  1  alarm arm switch
- TSec  in  6  current time seconds
- TMin  in  6  current time minutes
- THrs  in  5  current time hours
- TDay  in  3  current day
- AMin  in  6  alarm minutes
- AHrs  in  5  alarm hours
- SecEn, MinEn, HrsEn, DayEn  out  1 each  time counter advance enables
- AMinEn, AHrsEn  out  1 each  alarm counter advance enables
- DispAlarm  out  1  display mux select: 1 = show alarm registers
- Mode  out  2  registered mode (mode_t)
- Buzz  out  1  alarm sounder

Behaviour:

Mode FSM:
- Registered state with three values: RUN, TSET, ASET.
- Next state = Timeset ? TSET : Alarmset ? ASET : RUN. Timeset has priority when both buttons are pressed.
- Latency: a button change is reflected in Mode on the next Pulse edge.
- Reset low at an edge forces RUN.

Enables (combinational from registered Mode and inputs):
- While Reset=0, all enables = 0.
- Carry chain:
  - c_min = (TSec==SEC_MAX)
  - c_hrs = c_min & (TMin==MIN_MAX)
  - c_day = c_hrs & (THrs==HRS_MAX)
- RUN: SecEn=1, MinEn=c_min, HrsEn=c_hrs, DayEn=c_day, AMinEn=AHrsEn=0, DispAlarm=0.
- TSET:
  - SecEn=0 (seconds frozen).
  - MinEn=Minadv, HrsEn=Hrsadv, DayEn=Dayadv.
  - No carries: minute wrap does not bump hours, hour wrap does not bump day.
  - DispAlarm=0.
- ASET:
  - Time enables exactly as in RUN (clock keeps running).
  - AMinEn=Minadv, AHrsEn=Hrsadv; Dayadv ignored.
  - DispAlarm=1.
- Multiple advance buttons held at once: each asserted enable fires independently in the same cycle.

Buzz:
- Buzz is registered; reset value 0. An internal hold counter (width clog2(BUZZ_SECS+1)) resets to 0.
- match = Alarmon & (Mode!=TSET) & (TSec==0) & (TMin==AMin) & (THrs==AHrs) & ~WEEKEND_MASK[TDay].
- match at edge k makes Buzz=1 from edge k onward, with the counter loaded to BUZZ_SECS-1.
- Each following edge decrements the counter. Buzz drops at the edge where the counter is 0, giving exactly BUZZ_SECS high cycles.
- Alarmon=0 clears Buzz and the counter at the next edge.
- Clear has priority over set when both occur in the same cycle.
- Re-match while already buzzing reloads the counter.
- Reset mid-buzz clears both at that edge.
- Entering TSET does not stop an active Buzz; only the set condition is suppressed.

Decomposition:
- Package clock_pkg:
  - typedef enum logic[1:0] mode_t {RUN=2'b00, TSET=2'b01, ASET=2'b10}
  - width constants SEC_W=6, MIN_W=6, HRS_W=5, DAY_W=3
  - default max values
- One sub-module, alarm_buzz_timer: match-to-Buzz hold counter with params BUZZ_SECS, inputs match, Alarmon, Reset.
- FSM and enable decode stay in clock_mode_ctrl.

Test Plan:
- Reset=0 for 2 edges with Timeset=1 -> Mode=RUN, Buzz=0, all enables 0 while Reset low; Reset=1, Timeset=1 -> Mode=TSET after next edge.
- RUN with TDay=6, THrs=23, TMin=59, TSec=59 -> SecEn=MinEn=HrsEn=DayEn=1. With TSec=58 -> only SecEn=1.
- TSET, TMin=59, Minadv=1 -> MinEn=1, HrsEn=0, SecEn=0. Dayadv=1 -> DayEn=1. Timeset=Alarmset=1 -> Mode=TSET.
- ASET, Minadv=1 and Hrsadv=1, TSec=59, TMin=10 -> AMinEn=AHrsEn=1, SecEn=MinEn=1, HrsEn=0, DispAlarm=1.
- BUZZ_SECS=3, Alarmon=1, AHrs=7, AMin=30, TDay=2, time 07:30:00 -> Buzz high exactly 3 edges then low. Same with TDay=0 or 6 -> Buzz stays 0.
- Buzz active and Alarmon dropped to 0 -> Buzz=0 at the next edge. Alarmon=0 with a match in the same cycle -> Buzz stays 0. Reset=0 mid-buzz -> Buzz=0 at that edge.
